// File: rtl/equalizer_pkg.sv
// Shared constants and arithmetic helpers for the equalizer datapath blocks.
package equalizer_pkg;

  localparam int CMUL_MIN_LAT = 4;

  // Width at which re/im sums of two IN_W x (IN_W+1) products cannot overflow.
  function automatic int cmul_width(input int inW);
    return 2 * inW + 2;
  endfunction

  // Round half toward +inf, arithmetic shift right, then clamp to a signed outW range.
  function automatic logic signed [63:0] round_sat(
    input  logic signed [63:0] value,
    input  int                 shift,
    input  int                 outW,
    output logic               sat
  );
    logic signed [63:0] t;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    t   = (value + ((64'sd1 <<< shift) >>> 1)) >>> shift;
    hi  = (64'sd1 <<< (outW - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    sat = 1'b0;
    if (t > hi) begin
      t   = hi;
      sat = 1'b1;
    end else if (t < lo) begin
      t   = lo;
      sat = 1'b1;
    end
    return t;
  endfunction

endpackage

// File: rtl/equalizer_smul_pipe.sv
// Signed IN_W x (IN_W+1) multiplier with registered operands and registered product.
module equalizer_smul_pipe #(
  parameter int IN_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce,
  input  logic signed [IN_W-1:0] i_a,
  input  logic signed [IN_W:0]   i_b,
  output logic signed [2*IN_W:0] o_p
);

  localparam int PW = 2 * IN_W + 1;

  logic signed [IN_W-1:0] r_a;
  logic signed [IN_W:0]   r_b;
  logic signed [PW-1:0]   r_p;

  // The exact product always fits PW bits, so truncating a PW x PW multiply is lossless.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
      r_p <= '0;
    end else if (ce) begin
      r_a <= i_a;
      r_b <= i_b;
      r_p <= PW'(r_a) * PW'(r_b);
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/equalizer_cmul_pipe.sv
// Pipelined complex multiplier a*b or a*conj(b) with round/saturate and a valid flag.
module equalizer_cmul_pipe
  import equalizer_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 25,
  parameter int SHIFT = 0,
  parameter int LAT   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    in_valid,
  input  logic                    conj_b,
  input  logic signed [IN_W-1:0]  a_re,
  input  logic signed [IN_W-1:0]  a_im,
  input  logic signed [IN_W-1:0]  b_re,
  input  logic signed [IN_W-1:0]  b_im,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] p_re,
  output logic signed [OUT_W-1:0] p_im,
  output logic                    sat
);

  localparam int W     = cmul_width(IN_W);
  localparam int PW    = 2 * IN_W + 1;
  localparam int EXTRA = LAT - CMUL_MIN_LAT;

  logic signed [IN_W:0]    w_bRe;
  logic signed [IN_W:0]    w_bIm;
  logic signed [PW-1:0]    w_arbr;
  logic signed [PW-1:0]    w_aibi;
  logic signed [PW-1:0]    w_arbi;
  logic signed [PW-1:0]    w_aibr;
  logic signed [OUT_W-1:0] w_pRe;
  logic signed [OUT_W-1:0] w_pIm;
  logic                    w_satRe;
  logic                    w_satIm;

  logic [3:0]              r_validPipe;
  logic signed [W-1:0]     r_re;
  logic signed [W-1:0]     r_im;
  logic signed [OUT_W-1:0] r_pRe;
  logic signed [OUT_W-1:0] r_pIm;
  logic                    r_sat;

  // One extra bit lets conj negate the most negative b_im without wrapping.
  assign w_bRe = {b_re[IN_W-1], b_re};
  assign w_bIm = conj_b ? -{b_im[IN_W-1], b_im} : {b_im[IN_W-1], b_im};

  equalizer_smul_pipe #(.IN_W(IN_W)) u_arbr (.clk(clk), .reset(reset), .ce(ce), .i_a(a_re), .i_b(w_bRe), .o_p(w_arbr));
  equalizer_smul_pipe #(.IN_W(IN_W)) u_aibi (.clk(clk), .reset(reset), .ce(ce), .i_a(a_im), .i_b(w_bIm), .o_p(w_aibi));
  equalizer_smul_pipe #(.IN_W(IN_W)) u_arbi (.clk(clk), .reset(reset), .ce(ce), .i_a(a_re), .i_b(w_bIm), .o_p(w_arbi));
  equalizer_smul_pipe #(.IN_W(IN_W)) u_aibr (.clk(clk), .reset(reset), .ce(ce), .i_a(a_im), .i_b(w_bRe), .o_p(w_aibr));

  always_comb begin
    w_satRe = 1'b0;
    w_satIm = 1'b0;
    w_pRe   = OUT_W'(round_sat(64'(r_re), SHIFT, OUT_W, w_satRe));
    w_pIm   = OUT_W'(round_sat(64'(r_im), SHIFT, OUT_W, w_satIm));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_validPipe <= '0;
      r_re        <= '0;
      r_im        <= '0;
      r_pRe       <= '0;
      r_pIm       <= '0;
      r_sat       <= 1'b0;
    end else if (ce) begin
      r_validPipe <= {r_validPipe[2:0], in_valid};
      r_re        <= W'(w_arbr) - W'(w_aibi);
      r_im        <= W'(w_arbi) + W'(w_aibr);
      r_pRe       <= w_pRe;
      r_pIm       <= w_pIm;
      r_sat       <= w_satRe | w_satIm;
    end
  end

  // Latency beyond the minimum is a plain delay line behind the round/saturate stage.
  generate
    if (EXTRA == 0) begin : gNoDelay
      assign out_valid = r_validPipe[3];
      assign p_re      = r_pRe;
      assign p_im      = r_pIm;
      assign sat       = r_sat;
    end else begin : gDelay
      logic [EXTRA-1:0]        r_dValid;
      logic [EXTRA-1:0]        r_dSat;
      logic signed [OUT_W-1:0] r_dRe [EXTRA];
      logic signed [OUT_W-1:0] r_dIm [EXTRA];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_dValid <= '0;
          r_dSat   <= '0;
          for (int i = 0; i < EXTRA; i++) begin
            r_dRe[i] <= '0;
            r_dIm[i] <= '0;
          end
        end else if (ce) begin
          r_dValid[0] <= r_validPipe[3];
          r_dSat[0]   <= r_sat;
          r_dRe[0]    <= r_pRe;
          r_dIm[0]    <= r_pIm;
          for (int i = 1; i < EXTRA; i++) begin
            r_dValid[i] <= r_dValid[i-1];
            r_dSat[i]   <= r_dSat[i-1];
            r_dRe[i]    <= r_dRe[i-1];
            r_dIm[i]    <= r_dIm[i-1];
          end
        end
      end

      assign out_valid = r_dValid[EXTRA-1];
      assign p_re      = r_dRe[EXTRA-1];
      assign p_im      = r_dIm[EXTRA-1];
      assign sat       = r_dSat[EXTRA-1];
    end
  endgenerate

endmodule

// File: tb/tb_equalizer_cmul_pipe.sv
// Scoreboard bench for equalizer_cmul_pipe: default, rounding (SHIFT=15) and LAT=6 sweep instances.
module tb_equalizer_cmul_pipe;

  typedef struct {
    longint re;
    longint im;
    bit     sat;
    int     due;
  } exp_t;

  logic clk;
  logic reset;
  logic ce;

  logic              valid01, conj01;
  logic signed [15:0] aRe01, aIm01, bRe01, bIm01;
  logic              valid2, conj2;
  logic signed [11:0] aRe2, aIm2, bRe2, bIm2;

  logic              ov0, ov1, ov2, sat0, sat1, sat2;
  logic signed [24:0] pRe0, pIm0, pRe1, pIm1;
  logic signed [17:0] pRe2, pIm2;

  logic signed [63:0] obsRe [3];
  logic signed [63:0] obsIm [3];
  logic               obsV  [3];
  logic               obsS  [3];

  exp_t q [3][$];
  exp_t lastE [3];
  bit   lastV [3];
  int   edgeCnt;
  bit   lastEn;
  int   checks;
  int   errors;

  equalizer_cmul_pipe #(.IN_W(16), .OUT_W(25), .SHIFT(0), .LAT(4)) u0 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(valid01), .conj_b(conj01),
    .a_re(aRe01), .a_im(aIm01), .b_re(bRe01), .b_im(bIm01),
    .out_valid(ov0), .p_re(pRe0), .p_im(pIm0), .sat(sat0));

  equalizer_cmul_pipe #(.IN_W(16), .OUT_W(25), .SHIFT(15), .LAT(4)) u1 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(valid01), .conj_b(conj01),
    .a_re(aRe01), .a_im(aIm01), .b_re(bRe01), .b_im(bIm01),
    .out_valid(ov1), .p_re(pRe1), .p_im(pIm1), .sat(sat1));

  equalizer_cmul_pipe #(.IN_W(12), .OUT_W(18), .SHIFT(4), .LAT(6)) u2 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(valid2), .conj_b(conj2),
    .a_re(aRe2), .a_im(aIm2), .b_re(bRe2), .b_im(bIm2),
    .out_valid(ov2), .p_re(pRe2), .p_im(pIm2), .sat(sat2));

  always #5 clk = ~clk;

  always_comb begin
    obsRe[0] = 64'(pRe0); obsIm[0] = 64'(pIm0); obsV[0] = ov0; obsS[0] = sat0;
    obsRe[1] = 64'(pRe1); obsIm[1] = 64'(pIm1); obsV[1] = ov1; obsS[1] = sat1;
    obsRe[2] = 64'(pRe2); obsIm[2] = 64'(pIm2); obsV[2] = ov2; obsS[2] = sat2;
  end

  // Reference: exact complex product, round half up, clamp.
  function automatic exp_t model(input longint ar, ai, br, bi, input bit cj, input int shift, input int outW);
    exp_t   m;
    longint bip, hi, lo;
    bip = cj ? -bi : bi;
    m.re = ar * br - ai * bip;
    m.im = ar * bip + ai * br;
    if (shift > 0) begin
      m.re = (m.re + (longint'(1) << (shift - 1))) >>> shift;
      m.im = (m.im + (longint'(1) << (shift - 1))) >>> shift;
    end
    hi = (longint'(1) << (outW - 1)) - 1;
    lo = -hi - 1;
    m.sat = 1'b0;
    if (m.re > hi) begin m.re = hi; m.sat = 1'b1; end
    if (m.re < lo) begin m.re = lo; m.sat = 1'b1; end
    if (m.im > hi) begin m.im = hi; m.sat = 1'b1; end
    if (m.im < lo) begin m.im = lo; m.sat = 1'b1; end
    m.due = 0;
    return m;
  endfunction

  function automatic int pickS(input int w);
    int r;
    int v;
    r = int'($urandom_range(0, 7));
    if (r == 0) return -(1 << (w - 1));
    if (r == 1) return (1 << (w - 1)) - 1;
    v = int'($urandom_range(0, (1 << w) - 1));
    return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
  endfunction

  task automatic checkOutput(input string tag, input logic signed [63:0] obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drives the 16-bit pair (u0, u1) and records their expected results.
  task automatic applyStimulus(input bit en, input int ar, ai, br, bi, input bit cj, v,
                               input longint e0re, e0im, input bit e0s,
                               input longint e1re, e1im, input bit e1s);
    exp_t e;
    @(negedge clk);
    ce = en;
    aRe01 = 16'(ar); aIm01 = 16'(ai); bRe01 = 16'(br); bIm01 = 16'(bi);
    conj01 = cj;
    valid01 = v;
    if (en && v) begin
      e.re = e0re; e.im = e0im; e.sat = e0s; e.due = edgeCnt + 4;
      q[0].push_back(e);
      e.re = e1re; e.im = e1im; e.sat = e1s; e.due = edgeCnt + 4;
      q[1].push_back(e);
    end
  endtask

  task automatic applyModel(input bit en, input int ar, ai, br, bi, input bit cj, v);
    exp_t m0, m1;
    m0 = model(ar, ai, br, bi, cj, 0, 25);
    m1 = model(ar, ai, br, bi, cj, 15, 25);
    applyStimulus(en, ar, ai, br, bi, cj, v, m0.re, m0.im, m0.sat, m1.re, m1.im, m1.sat);
  endtask

  // Called right after applyStimulus in the same time step, so ce is already settled.
  task automatic applyWide(input int ar, ai, br, bi, input bit cj, v);
    exp_t m;
    aRe2 = 12'(ar); aIm2 = 12'(ai); bRe2 = 12'(br); bIm2 = 12'(bi);
    conj2 = cj;
    valid2 = v;
    if (ce && v) begin
      m = model(ar, ai, br, bi, cj, 4, 18);
      m.due = edgeCnt + 6;
      q[2].push_back(m);
    end
  endtask

  task automatic applyIdle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(posedge clk) begin
    lastEn = ce;
    if (ce) edgeCnt++;
  end

  // Scoreboard: pops on enabled edges, checks hold behaviour on stalled edges.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        if (lastEn) begin
          if (q[i].size() > 0 && q[i][0].due == edgeCnt) begin
            e = q[i].pop_front();
            checkOutput($sformatf("u%0d_valid", i), 64'(obsV[i]), 1);
            checkOutput($sformatf("u%0d_re", i), obsRe[i], e.re);
            checkOutput($sformatf("u%0d_im", i), obsIm[i], e.im);
            checkOutput($sformatf("u%0d_sat", i), 64'(obsS[i]), longint'(e.sat));
            lastE[i] = e;
            lastV[i] = 1'b1;
          end else begin
            checkOutput($sformatf("u%0d_idle_valid", i), 64'(obsV[i]), 0);
            lastV[i] = 1'b0;
          end
        end else begin
          checkOutput($sformatf("u%0d_hold_valid", i), 64'(obsV[i]), longint'(lastV[i]));
          if (lastV[i]) begin
            checkOutput($sformatf("u%0d_hold_re", i), obsRe[i], lastE[i].re);
            checkOutput($sformatf("u%0d_hold_im", i), obsIm[i], lastE[i].im);
            checkOutput($sformatf("u%0d_hold_sat", i), 64'(obsS[i]), longint'(lastE[i].sat));
          end
        end
      end
    end
  end

  initial begin
    int nValid;
    int steps;
    bit en;
    clk = 1'b0; reset = 1'b1; ce = 1'b1;
    valid01 = 0; conj01 = 0; aRe01 = 0; aIm01 = 0; bRe01 = 0; bIm01 = 0;
    valid2 = 0; conj2 = 0; aRe2 = 0; aIm2 = 0; bRe2 = 0; bIm2 = 0;
    checks = 0; errors = 0; edgeCnt = 0; lastEn = 1'b0;

    #2;
    checkOutput("rst_u0_valid", 64'(ov0), 0);
    checkOutput("rst_u0_re", obsRe[0], 0);
    checkOutput("rst_u0_im", obsIm[0], 0);
    checkOutput("rst_u0_sat", 64'(sat0), 0);
    checkOutput("rst_u2_valid", 64'(ov2), 0);
    @(negedge clk);
    reset = 1'b0;
    applyIdle(2);

    // (3+4j)(5-2j) = 23+14j; SHIFT=15 rounds both parts to 0.
    applyStimulus(1, 3, 4, 5, -2, 0, 1, 23, 14, 0, 0, 0, 0);
    applyIdle(5);

    // Alternating conj: (3+4j)(5+2j) = 7+26j.
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) applyStimulus(1, 3, 4, 5, -2, 0, 1, 23, 14, 0, 0, 0, 0);
      else            applyStimulus(1, 3, 4, 5, -2, 1, 1, 7, 26, 0, 0, 0, 0);
    end
    applyIdle(3);

    // Saturation: re=2^31 (conj), im=2^31 (normal), im=-2147450880 (conj, b=32767-32768j).
    applyStimulus(1, -32768, -32768, -32768, -32768, 1, 1, 16777215, 0, 1, 65536, 0, 0);
    applyStimulus(1, -32768, -32768, -32768, -32768, 0, 1, 0, 16777215, 1, 0, 65536, 0);
    applyStimulus(1, -32768, -32768, 32767, -32768, 1, 1, 32768, -16777216, 1, 1, -65535, 0);
    applyIdle(2);

    // Rounding at SHIFT=15 on u1: +0.5 -> 1, -0.5 -> 0, just below -0.5 -> -1.
    applyStimulus(1, 16384, 0, 1, 0, 0, 1, 16384, 0, 0, 1, 0, 0);
    applyStimulus(1, -16384, 0, 1, 0, 0, 1, -16384, 0, 0, 0, 0, 0);
    applyStimulus(1, -16385, 0, 1, 0, 0, 1, -16385, 0, 0, -1, 0, 0);
    applyIdle(6);

    // Six valid samples with a three-cycle ce stall after the fifth.
    for (int k = 0; k < 5; k++) applyModel(1, pickS(16), pickS(16), pickS(16), pickS(16), k[0], 1);
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    applyModel(1, pickS(16), pickS(16), pickS(16), pickS(16), 1, 1);
    applyIdle(6);

    // Asynchronous reset mid-stream.
    for (int k = 0; k < 4; k++) applyModel(1, 1000 + k, -2000, 3000, 400 - k, 0, 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    valid01 = 1'b0;
    valid2 = 1'b0;
    #1;
    checkOutput("async_rst_u0_valid", 64'(ov0), 0);
    checkOutput("async_rst_u0_re", obsRe[0], 0);
    checkOutput("async_rst_u0_im", obsIm[0], 0);
    checkOutput("async_rst_u0_sat", 64'(sat0), 0);
    checkOutput("async_rst_u1_valid", 64'(ov1), 0);
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      lastV[i] = 1'b0;
    end
    @(negedge clk);
    reset = 1'b0;
    applyIdle(8);

    // Random sweep: u2 mostly valid, u0/u1 valid toggling each step, occasional stalls.
    nValid = 0;
    steps = 0;
    while (nValid < 1000 && steps < 5000) begin
      en = ($urandom_range(0, 15) != 0);
      applyModel(en, pickS(16), pickS(16), pickS(16), pickS(16), 1'($urandom_range(0, 1)), steps[0]);
      applyWide(pickS(12), pickS(12), pickS(12), pickS(12), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) != 0));
      if (en && valid2) nValid++;
      steps++;
    end
    checkOutput("sweep_count", 64'(nValid), 1000);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyWide(0, 0, 0, 0, 0, 0);
    applyIdle(10);

    for (int i = 0; i < 3; i++) checkOutput($sformatf("u%0d_drain", i), 64'(q[i].size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
